// File: rtl/lfsr_chk_pkg.sv
// Shared types and helpers for the LFSR stream checker (see lfsr_stream_checker,
// optional signature compare enabled by LFSR_CHK_SIG_EN).
package lfsr_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } chk_state_e;

    localparam logic [63:0] LFSR_DEFAULT_SEED = 64'h5aef0c8d_d70a4497;
    localparam logic [15:0] IDX_NONE          = 16'hFFFF;

    // One step of the 64-bit LFSR; shared by the expected sequence and the MISR.
    function automatic logic [63:0] lfsr64_next(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[2] ^ s[0]};
    endfunction

endpackage

// File: rtl/misr64.sv
// 64-bit MISR folding 32-bit words into a signature using the shared LFSR step.
module misr64
    import lfsr_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [63:0] sig
);

    // Signature register: clear wins over fold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 64'h0;
        end else if (clr) begin
            sig <= 64'h0;
        end else if (en) begin
            sig <= {32'h0, din} ^ lfsr64_next(sig);
        end else begin
            sig <= sig;
        end
    end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receive-side LFSR stream checker: compares words against the regenerated sequence
// and signs them with a MISR. Define LFSR_CHK_SIG_EN to fold EXP_SIG into pass.
module lfsr_stream_checker
    import lfsr_chk_pkg::*;
#(
    parameter logic [63:0] SEED      = LFSR_DEFAULT_SEED,
    parameter int          NUM_WORDS = 80,
    parameter logic [63:0] EXP_SIG   = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx,
    output logic [63:0] signature
);

    localparam logic [15:0] LAST_BEAT = 16'(NUM_WORDS - 1);

    chk_state_e  r_state;
    chk_state_e  w_state_nxt;
    logic [63:0] r_exp;
    logic [15:0] r_beat;
    logic [15:0] r_err_count;
    logic [15:0] r_first_err;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;

    logic        w_load;
    logic        w_acc;
    logic        w_last;
    logic        w_mismatch;
    logic [15:0] w_err_nxt;
    logic [63:0] w_sig;
    logic [63:0] w_sig_nxt;
    logic        w_sig_ok;
    logic        w_pass_nxt;

    // A start in CHECK takes priority over the beat presented in the same cycle.
    assign w_load     = start && ((r_state == IDLE) || (r_state == CHECK));
    assign w_acc      = in_valid && (r_state == CHECK) && !start;
    assign w_last     = (r_beat == LAST_BEAT);
    assign w_mismatch = w_acc && (in_data != r_exp[31:0]);
    assign w_err_nxt  = (w_mismatch && (r_err_count != 16'hFFFF)) ? (r_err_count + 16'd1) : r_err_count;
    assign w_sig_nxt  = {32'h0, in_data} ^ lfsr64_next(w_sig);

`ifdef LFSR_CHK_SIG_EN
    assign w_sig_ok   = (w_sig_nxt == EXP_SIG);
`else
    // Signature compare is masked out in this build; pass depends on errors only.
    assign w_sig_ok   = 1'b1 | (w_sig_nxt == EXP_SIG);
`endif

    assign w_pass_nxt = (w_err_nxt == 16'd0) && w_sig_ok;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? CHECK : IDLE;
            CHECK: begin
                if (start) begin
                    w_state_nxt = CHECK;
                end else if (w_acc && w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = CHECK;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Expected sequence, beat counter, error tracking and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp       <= 64'h0;
            r_beat      <= 16'd0;
            r_err_count <= 16'd0;
            r_first_err <= IDX_NONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == CHECK);
            r_done <= (w_state_nxt == DONE);
            if (w_load) begin
                r_exp       <= SEED;
                r_beat      <= 16'd0;
                r_err_count <= 16'd0;
                r_first_err <= IDX_NONE;
                r_pass      <= 1'b0;
            end else if (w_acc) begin
                r_exp       <= lfsr64_next(r_exp);
                r_beat      <= r_beat + 16'd1;
                r_err_count <= w_err_nxt;
                if (w_mismatch && (r_first_err == IDX_NONE)) begin
                    r_first_err <= r_beat;
                end else begin
                    r_first_err <= r_first_err;
                end
                if (w_last) begin
                    r_pass <= w_pass_nxt;
                end else begin
                    r_pass <= r_pass;
                end
            end else begin
                r_exp <= r_exp;
            end
        end
    end

    misr64 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_load),
        .en    (w_acc),
        .din   (in_data),
        .sig   (w_sig)
    );

    assign in_ready      = (r_state == CHECK);
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err;
    assign signature     = w_sig;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboard bench for lfsr_stream_checker; reference model computed from the stream rules.
module tb_lfsr_stream_checker;

    localparam logic [63:0] SEED = 64'h5aef0c8d_d70a4497;
    localparam int          N    = 80;

    function automatic logic [63:0] step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[2] ^ s[0]};
    endfunction

    function automatic logic [63:0] calc_gold();
        logic [63:0] e, s;
        e = SEED;
        s = 64'h0;
        for (int i = 0; i < N; i++) begin
            s = {32'h0, e[31:0]} ^ step(s);
            e = step(e);
        end
        return s;
    endfunction

    localparam logic [63:0] GOLD_SIG = calc_gold();
    localparam logic [63:0] B_SIG    = 64'h0000_0000_d70a_4497;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_start, a_valid, a_ready, a_busy, a_done, a_pass;
    logic [31:0] a_data;
    logic [15:0] a_err, a_first;
    logic [63:0] a_sig;
    logic        b_start, b_valid, b_ready, b_busy, b_done, b_pass;
    logic [31:0] b_data;
    logic [15:0] b_err, b_first;
    logic [63:0] b_sig;

    lfsr_stream_checker #(.SEED(SEED), .NUM_WORDS(N), .EXP_SIG(GOLD_SIG)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .first_err_idx(a_first), .signature(a_sig));

    lfsr_stream_checker #(.SEED(SEED), .NUM_WORDS(1), .EXP_SIG(B_SIG)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_err_idx(b_first), .signature(b_sig));

    typedef struct {
        logic        pass;
        logic [15:0] errs;
        logic [15:0] first;
        logic [63:0] sig;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int total = 0;
    int bad = 0;
    int last_hs_a = 0;
    int last_hs_b = 0;
    logic [31:0] gold [N];
    logic [31:0] stim [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t model(input int n, input logic [63:0] xsig);
        exp_t r;
        logic [63:0] e, s;
        e = SEED;
        s = 64'h0;
        r.errs = 16'd0;
        r.first = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (stim[i] != e[31:0]) begin
                if (r.errs != 16'hFFFF) r.errs = r.errs + 16'd1;
                if (r.first == 16'hFFFF) r.first = i[15:0];
            end
            s = {32'h0, stim[i]} ^ step(s);
            e = step(e);
        end
        r.sig = s;
`ifdef LFSR_CHK_SIG_EN
        r.pass = (r.errs == 16'd0) && (s == xsig);
`else
        r.pass = (r.errs == 16'd0);
`endif
        return r;
    endfunction

    task automatic push_a();
        qa.push_back(model(N, GOLD_SIG));
`ifdef LFSR_CHK_SIG_EN
        qc.push_back(model(N, GOLD_SIG ^ 64'h1));
`endif
    endtask

    always @(negedge clk) begin : mon_a
        exp_t x;
        if (rst_n && a_done) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_done actual=1 required=0");
            end else begin
                x = qa.pop_front();
                chk("a_pass", a_pass, x.pass);
                chk("a_err_count", a_err, x.errs);
                chk("a_first_err_idx", a_first, x.first);
                chk("a_signature", a_sig, x.sig);
                chk("a_done_cycle", cyc, last_hs_a);
                chk("a_ready_drop", a_ready, 1'b0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t x;
        if (rst_n && b_done) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_done actual=1 required=0");
            end else begin
                x = qb.pop_front();
                chk("b_pass", b_pass, x.pass);
                chk("b_err_count", b_err, x.errs);
                chk("b_first_err_idx", b_first, x.first);
                chk("b_signature", b_sig, x.sig);
                chk("b_done_cycle", cyc, last_hs_b);
            end
        end
    end

`ifdef LFSR_CHK_SIG_EN
    logic        c_ready, c_busy, c_done, c_pass;
    logic [15:0] c_err, c_first;
    logic [63:0] c_sig;

    lfsr_stream_checker #(.SEED(SEED), .NUM_WORDS(N), .EXP_SIG(GOLD_SIG ^ 64'h1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_ready(c_ready),
        .in_data(a_data), .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
        .first_err_idx(c_first), .signature(c_sig));

    always @(negedge clk) begin : mon_c
        exp_t x;
        if (rst_n && c_done) begin
            if (qc.size() == 0) begin
                total++; bad++;
                $display("FAIL c_unexpected_done actual=1 required=0");
            end else begin
                x = qc.pop_front();
                chk("c_pass", c_pass, x.pass);
                chk("c_signature", c_sig, x.sig);
                chk("c_done_cycle", cyc, last_hs_a);
            end
        end
    end
`endif

    task automatic chk_reset_a(input string tag);
        chk({tag, "_ready"}, a_ready, 1'b0);
        chk({tag, "_busy"}, a_busy, 1'b0);
        chk({tag, "_done"}, a_done, 1'b0);
        chk({tag, "_pass"}, a_pass, 1'b0);
        chk({tag, "_err"}, a_err, 16'd0);
        chk({tag, "_first"}, a_first, 16'hFFFF);
        chk({tag, "_sig"}, a_sig, 64'h0);
    endtask

    task automatic drive_a(input int gap_pct, input int abort_at, input int reset_at);
        int k, guard;
        bit aborted;
        k = 0; guard = 0; aborted = 1'b0;
        @(negedge clk); a_start = 1'b1; a_valid = 1'b0;
        @(negedge clk); a_start = 1'b0;
        chk("a_busy_after_start", a_busy, 1'b1);
        chk("a_ready_after_start", a_ready, 1'b1);
        while (k < N && guard < 4000) begin
            a_data  = stim[k];
            a_valid = ($urandom_range(99) >= gap_pct);
            if (!aborted && abort_at >= 0 && k == 10) a_data = stim[k] ^ 32'h4;
            if (k == reset_at) begin
                a_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_reset_a("midrun_reset");
                @(negedge clk); rst_n = 1'b1;
                return;
            end
            if (!aborted && k == abort_at) begin
                chk("a_err_before_abort", a_err, 16'd1);
                a_start = 1'b1; a_valid = 1'b1; aborted = 1'b1;
                @(negedge clk); a_start = 1'b0;
                chk("abort_err", a_err, 16'd0);
                chk("abort_first", a_first, 16'hFFFF);
                chk("abort_sig", a_sig, 64'h0);
                k = 0; guard++;
                continue;
            end
            if (a_valid && a_ready) begin
                k++;
                last_hs_a = cyc + 1;
            end
            @(negedge clk); guard++;
        end
        a_valid = 1'b0;
        if (guard >= 4000) begin
            total++; bad++;
            $display("FAIL a_stream_timeout actual=%0d required=%0d", k, N);
        end
    endtask

    initial begin
        logic [63:0] e;
        e = SEED;
        for (int i = 0; i < N; i++) begin
            gold[i] = e[31:0];
            e = step(e);
        end
        a_start = 1'b0; a_valid = 1'b0; a_data = 32'h0;
        b_start = 1'b0; b_valid = 1'b0; b_data = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_a("reset_a");
        chk("reset_b_ready", b_ready, 1'b0);
        chk("reset_b_first", b_first, 16'hFFFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < N; i++) stim[i] = gold[i];
        push_a(); drive_a(0, -1, -1); repeat (3) @(negedge clk);

        stim[5]  = gold[5] ^ 32'h1;
        stim[40] = gold[40] ^ 32'h8000_0000;
        push_a(); drive_a(0, -1, -1); repeat (3) @(negedge clk);

        for (int i = 0; i < N; i++) stim[i] = gold[i];
        push_a(); drive_a(50, -1, -1); repeat (3) @(negedge clk);

        push_a(); drive_a(0, 30, -1); repeat (3) @(negedge clk);

        drive_a(0, -1, 30); repeat (3) @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++)
                stim[i] = ($urandom_range(99) < 6) ? (gold[i] ^ (32'h1 << $urandom_range(31))) : gold[i];
            push_a(); drive_a($urandom_range(70), -1, -1); repeat (3) @(negedge clk);
        end

        stim[0] = gold[0];
        qb.push_back(model(1, B_SIG));
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0; b_valid = 1'b1; b_data = stim[0];
        chk("b_ready_after_start", b_ready, 1'b1);
        last_hs_b = cyc + 1;
        @(negedge clk); b_valid = 1'b0;
        chk("b_signature_const", b_sig, B_SIG);
        repeat (3) @(negedge clk);

        for (int t = 0; t < 50 && (qa.size() + qb.size() + qc.size()) != 0; t++) @(negedge clk);
        if ((qa.size() + qb.size() + qc.size()) != 0) begin
            total++; bad++;
            $display("FAIL pending_results actual=%0d required=0", qa.size() + qb.size() + qc.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Receive-side checker for the 64-bit LFSR test stream used by our regression benches. The checker regenerates the expected sequence locally (feedback `{s[62:0], s[63]^s[2]^s[0]}`, low 32 bits per word) from a known seed. It compares each accepted word against that expected sequence and folds every word into a 64-bit MISR signature. The block sits at the output of a device under test and reports pass/fail, a mismatch count, and the final signature.

## Interface
Parameters:
- SEED, 64'h5aef0c8d_d70a4497: expected-sequence state loaded on `start`.
- NUM_WORDS, 80: number of words checked per run. Legal range is 1..65535.
- EXP_SIG, 64'h0: expected final MISR signature. Used only when `LFSR_CHK_SIG_EN` is defined.

Ports:
- clk  in  1  Sole clock; all logic samples on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- start  in  1  One-cycle pulse that begins a run.
- in_valid  in  1  Upstream word valid.
- in_ready  out  1  Checker can accept a word.
- in_data  in  32  Word under check.
- busy  out  1  A run is in progress.
- done  out  1  One-cycle pulse when a run completes.
- pass  out  1  Result of the last run; held until the next `start`.
- err_count  out  16  Mismatching words in the current run; saturates at 16'hFFFF.
- first_err_idx  out  16  Beat index of the first mismatch. Reads 16'hFFFF if there was none.
- signature  out  64  Current MISR value.

## Operation
- States:
  - IDLE: waiting for a run.
  - CHECK: accepting and checking words.
  - DONE: one-cycle completion state.
- IDLE → CHECK on `start`. Loads:
  - exp ← SEED
  - sig ← 0
  - beat ← 0
  - err_count ← 0
  - first_err_idx ← 16'hFFFF
  - pass ← 0
- A beat is accepted when `in_valid && in_ready`. `in_ready` = (state == CHECK), combinational from state only.
- On each accepted beat:
  - Mismatch if `in_data != exp[31:0]`. On a mismatch, increment `err_count` (saturating). If `first_err_idx` is still 16'hFFFF, latch the current beat index into it.
  - exp ← {exp[62:0], exp[63]^exp[2]^exp[0]}
  - sig ← {32'h0, in_data} ^ {sig[62:0], sig[63]^sig[2]^sig[0]}
  - beat ← beat + 1
- After the beat where beat == NUM_WORDS-1 is accepted, go CHECK → DONE.
- DONE lasts one cycle:
  - `done` = 1.
  - `pass` ← (err_count == 0), plus the signature term below.
  - Then → IDLE.
- `start` while in CHECK aborts the run. The checker reloads exactly as from IDLE; a beat presented in that same cycle is not accepted.
- `start` while in DONE is ignored.
- Cycles without a handshake (`in_valid` = 0) do not advance exp, sig or beat.

## Timing
- Reset values:
  - state = IDLE
  - in_ready = 0, busy = 0, done = 0, pass = 0
  - err_count = 0
  - first_err_idx = 16'hFFFF
  - signature = 0
- Registered outputs: `busy`, `done`, `pass`, `err_count`, `first_err_idx`, `signature`.
- `in_ready` rises in the cycle after `start`.
- After the last beat is accepted:
  - `done` pulses one cycle later.
  - `pass` becomes valid in that same cycle.
  - `in_ready` drops in the cycle after the last handshake.
- Throughput is one word per cycle.
- Reset asserted mid-run returns everything to reset values immediately, asynchronously.

## Configuration
- `LFSR_CHK_SIG_EN` defined:
  - pass = (err_count == 0) && (sig == EXP_SIG), evaluated on the final signature.
- `LFSR_CHK_SIG_EN` undefined:
  - pass = (err_count == 0).
  - EXP_SIG is unused.
  - `signature` is still computed and output.

## Structure
- Package `lfsr_chk_pkg` holds:
  - function `lfsr64_next(logic [63:0])`, used for both the expected-sequence step and the MISR shift.
  - the `chk_state_e` enum (IDLE/CHECK/DONE).
  - constant `LFSR_DEFAULT_SEED`.
- Sub-module `misr64`:
  - Ports: clr, en, din[31:0], sig[63:0].
  - Instantiated once for the signature.
- FSM, comparator and counters live in the top level.

## Test plan
1. Reset, then `start`. Drive 80 correct words from SEED, `in_valid` held high. Required: `done` pulse 1 cycle after beat 79; pass = 1, err_count = 0, first_err_idx = 16'hFFFF.
2. Same stream as scenario 1, but XOR beat 5 with 32'h1 and beat 40 with 32'h8000_0000. Required: err_count = 2, first_err_idx = 5, pass = 0.
3. Correct stream with random `in_valid` gaps at roughly 50% density. Required: the same `signature` as scenario 1, and `done` only after exactly 80 handshakes.
4. Abort and reset mid-run:
   - Assert `start` at beat 30. Required: beat counter restarts, the next accepted word is compared against SEED[31:0], then a full 80-beat pass.
   - Separately, assert `rst_n` low at beat 30. Required: immediate IDLE and all outputs at reset values.
5. With `LFSR_CHK_SIG_EN` defined, check both settings of EXP_SIG against the final signature from scenario 1:
   - EXP_SIG equal to that signature → pass = 1.
   - EXP_SIG with that signature's bit 0 flipped, clean stream → pass = 0.
6. NUM_WORDS = 1 with one correct word (SEED[31:0] = 32'hd70a4497). Required: `done` pulse 1 cycle after the handshake, pass = 1, signature = 64'h0000_0000_d70a_4497.
